// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: one iterative double-dabble binary-to-BCD engine shared
// round-robin among N_REQ requesters. A granted value is converted with one
// add-3/shift step per clock, and the digits are returned with the ID of the
// requester that owns them over a valid/ready handshake.
module bcd_conv_sched #(
    parameter int N_REQ = 3,
    parameter int W     = 16,
    parameter int ND    = 5,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic [ND*4-1:0]      out_digits,
    output logic                 busy
);

    localparam int SW = ND * 4 + W;       // BCD digits above the binary value
    localparam int CW = $clog2(W + 1);    // step counter must reach W

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]      sh_q, sh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               out_valid_q, out_valid_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic [ND*4-1:0]    out_digits_q, out_digits_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [ND*4-1:0]    bcd_adj;
    logic [SW-1:0]      sh_adj;
    logic [SW-1:0]      sh_step;

    // Round-robin search: first valid requester starting at rr_ptr and wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    // Each BCD nibble is corrected independently; a nibble >= 5 becomes at
    // most 12, so the +3 never carries into its neighbour.
    for (genvar gi = 0; gi < ND; gi++) begin : g_add3
        assign bcd_adj[gi*4 +: 4] = (sh_q[W + gi*4 +: 4] >= 4'd5)
                                  ? sh_q[W + gi*4 +: 4] + 4'd3
                                  : sh_q[W + gi*4 +: 4];
    end

    assign sh_adj  = {bcd_adj, sh_q[W-1:0]};
    assign sh_step = {sh_adj[SW-2:0], 1'b0};

    // Accept is one-hot on the grant and only offered while the engine is idle.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath: load on accept, W correction/shift steps, then
    // publish the digits and hold them until the consumer takes them.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_digits_d = out_digits_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    sh_d     = {{(ND*4){1'b0}}, req_data[int'(grant_idx)*W +: W]};
                    cnt_d    = '0;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CW'(W)) begin
                    // All W steps done: the upper ND*4 bits are the decimal result.
                    out_valid_d  = 1'b1;
                    out_digits_d = sh_q[SW-1 -: ND*4];
                    out_id_d     = id_q;
                    state_d      = S_DONE;
                end else begin
                    sh_d  = sh_step;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            sh_q         <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_digits_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_digits_q <= out_digits_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_digits = out_digits_q;
    assign busy       = (state_q != S_IDLE);

endmodule
